// File: rtl/sram_like_bram_bridge.sv
// SRAM-like master to synchronous block RAM bridge.
// One outstanding request, byte lanes, read-latency wait, misalign error.
module sram_like_bram_bridge #(
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  input  logic [31:0]       bram_dout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        data_ok_q, data_ok_d;
  logic        err_q, err_d;

  logic        accept;
  logic        misalign;
  logic [3:0]  lane;
  logic [31:0] din;
  logic        unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];

  assign addr_ok = (state_q == S_IDLE);
  assign accept  = req & addr_ok;

  // Byte lanes, replicated write data and alignment check from size/addr
  always_comb begin
    lane     = 4'b0000;
    din      = wdata;
    misalign = 1'b0;
    case (size)
      2'd0: begin
        lane = 4'b0001 << addr[1:0];
        din  = {4{wdata[7:0]}};
      end
      2'd1: begin
        lane     = addr[1] ? 4'b1100 : 4'b0011;
        din      = {2{wdata[15:0]}};
        misalign = addr[0];
      end
      2'd2: begin
        lane     = 4'b1111;
        misalign = |addr[1:0];
      end
      default: misalign = 1'b1;
    endcase
  end

  assign bram_addr = addr[ADDR_W+1:2];
  assign bram_din  = din;
  assign bram_en   = accept & ~misalign;
  assign bram_we   = (bram_en & wr) ? lane : 4'b0000;

  // Transaction sequencing: accept, optional read wait, one-cycle response
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    data_ok_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (misalign) begin
            state_d   = S_RESP;
            data_ok_d = 1'b1;
            err_d     = 1'b1;
          end else if (wr) begin
            state_d   = S_RESP;
            data_ok_d = 1'b1;
          end else begin
            state_d = S_RD_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d   = bram_dout;
          state_d   = S_RESP;
          data_ok_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      rdata_q   <= 32'd0;
      data_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      data_ok_q <= data_ok_d;
      err_q     <= err_d;
    end
  end

  assign data_ok = data_ok_q;
  assign err     = err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_sram_like_bram_bridge.sv
// Bench for sram_like_bram_bridge: RD_LAT=1 vector table, RD_LAT=3
// held-request and mid-transaction reset sequences.
module tb_sram_like_bram_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // DUT0: RD_LAT = 1
  logic        rstn0, req0, wr0;
  logic [1:0]  size0;
  logic [31:0] addr0, wdata0;
  logic        addr_ok0, data_ok0, err0, en0;
  logic [31:0] rdata0, din0, dout0;
  logic [3:0]  we0;
  logic [14:0] baddr0;

  sram_like_bram_bridge #(.ADDR_W(15), .RD_LAT(1)) u0 (
    .clk(clk), .rstn(rstn0), .req(req0), .wr(wr0), .size(size0),
    .addr(addr0), .wdata(wdata0), .addr_ok(addr_ok0),
    .data_ok(data_ok0), .rdata(rdata0), .err(err0), .bram_en(en0),
    .bram_we(we0), .bram_addr(baddr0), .bram_din(din0),
    .bram_dout(dout0)
  );

  // DUT1: RD_LAT = 3
  logic        rstn1, req1, wr1;
  logic [1:0]  size1;
  logic [31:0] addr1, wdata1;
  logic        addr_ok1, data_ok1, err1, en1;
  logic [31:0] rdata1, din1, dout1;
  logic [3:0]  we1;
  logic [14:0] baddr1;

  sram_like_bram_bridge #(.ADDR_W(15), .RD_LAT(3)) u1 (
    .clk(clk), .rstn(rstn1), .req(req1), .wr(wr1), .size(size1),
    .addr(addr1), .wdata(wdata1), .addr_ok(addr_ok1),
    .data_ok(data_ok1), .rdata(rdata1), .err(err1), .bram_en(en1),
    .bram_we(we1), .bram_addr(baddr1), .bram_din(din1),
    .bram_dout(dout1)
  );

  // RAM models
  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];
  logic [31:0] r0_d0;
  logic [31:0] r1_d0, r1_d1, r1_d2;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 32'd0;
      mem1[i] = 32'd0;
    end
    mem1[0] = 32'hCAFEF00D;
  end

  always @(posedge clk) begin
    if (en0) begin
      r0_d0 <= mem0[baddr0[9:0]];
      for (int b = 0; b < 4; b++)
        if (we0[b]) mem0[baddr0[9:0]][8*b+:8] <= din0[8*b+:8];
    end
  end
  assign dout0 = r0_d0;

  always @(posedge clk) begin
    if (en1) begin
      r1_d0 <= mem1[baddr1[9:0]];
      for (int b = 0; b < 4; b++)
        if (we1[b]) mem1[baddr1[9:0]][8*b+:8] <= din1[8*b+:8];
    end
    r1_d1 <= r1_d0;
    r1_d2 <= r1_d1;
  end
  assign dout1 = r1_d2;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        en;
    logic [3:0]  we;
    logic        chk_din;
    logic [31:0] din;
    logic        err;
    int          lat;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(
    input logic w, input logic [1:0] s, input logic [31:0] a,
    input logic [31:0] wd, input logic e, input logic [3:0] we,
    input logic cd, input logic [31:0] d, input logic er,
    input int l, input logic cr, input logic [31:0] r);
    vec_t v;
    v.wr = w; v.size = s; v.addr = a; v.wdata = wd;
    v.en = e; v.we = we; v.chk_din = cd; v.din = d;
    v.err = er; v.lat = l; v.chk_rd = cr; v.rd = r;
    return v;
  endfunction

  task automatic run_vec(input int k);
    vec_t v;
    int   n;
    logic busy_en;
    v = vt[k];
    @(negedge clk);
    req0 = 1'b1; wr0 = v.wr; size0 = v.size;
    addr0 = v.addr; wdata0 = v.wdata;
    #1;
    chk($sformatf("v%0d addr_ok", k), 32'(addr_ok0), 32'd1);
    chk($sformatf("v%0d en", k), 32'(en0), 32'(v.en));
    chk($sformatf("v%0d we", k), 32'(we0), 32'(v.we));
    if (v.en)
      chk($sformatf("v%0d baddr", k), 32'(baddr0),
          32'(v.addr[16:2]));
    if (v.chk_din)
      chk($sformatf("v%0d din", k), din0, v.din);
    @(negedge clk);
    req0 = 1'b0;
    wr0 = ~v.wr; addr0 = 32'hFFFF_FFFF; wdata0 = 32'h0;
    #1;
    n = 1;
    busy_en = 1'b0;
    while (!data_ok0 && n < 10) begin
      busy_en |= en0;
      @(negedge clk);
      #1;
      n++;
    end
    busy_en |= en0;
    chk($sformatf("v%0d latency", k), 32'(n), 32'(v.lat));
    chk($sformatf("v%0d err", k), 32'(err0), 32'(v.err));
    chk($sformatf("v%0d busy_en", k), 32'(busy_en), 32'd0);
    if (v.chk_rd)
      chk($sformatf("v%0d rdata", k), rdata0, v.rd);
  endtask

  initial begin
    int n;
    rstn0 = 1'b0; rstn1 = 1'b0;
    req0 = 1'b0; wr0 = 1'b0; size0 = 2'd2; addr0 = 0; wdata0 = 0;
    req1 = 1'b0; wr1 = 1'b0; size1 = 2'd2; addr1 = 0; wdata1 = 0;

    vt[0]  = mk(1, 2, 32'h100, 32'hDEADBEEF, 1, 4'hF, 1,
                32'hDEADBEEF, 0, 1, 0, 0);
    vt[1]  = mk(0, 2, 32'h100, 0, 1, 4'h0, 0, 0, 0, 2, 1,
                32'hDEADBEEF);
    vt[2]  = mk(1, 0, 32'h103, 32'hAA, 1, 4'h8, 1,
                32'hAAAAAAAA, 0, 1, 0, 0);
    vt[3]  = mk(0, 2, 32'h100, 0, 1, 4'h0, 0, 0, 0, 2, 1,
                32'hAAADBEEF);
    vt[4]  = mk(1, 1, 32'h102, 32'h1234, 1, 4'hC, 1,
                32'h12341234, 0, 1, 0, 0);
    vt[5]  = mk(1, 1, 32'h101, 32'h5678, 0, 4'h0, 0, 0, 1, 1, 1,
                32'hAAADBEEF);
    vt[6]  = mk(0, 2, 32'h100, 0, 1, 4'h0, 0, 0, 0, 2, 1,
                32'h1234BEEF);
    vt[7]  = mk(0, 1, 32'h101, 0, 0, 4'h0, 0, 0, 1, 1, 1,
                32'h1234BEEF);
    vt[8]  = mk(1, 3, 32'h104, 32'h11111111, 0, 4'h0, 0, 0, 1, 1,
                0, 0);
    vt[9]  = mk(1, 0, 32'h105, 32'h55, 1, 4'h2, 1, 32'h55555555,
                0, 1, 0, 0);
    vt[10] = mk(1, 2, 32'h106, 32'h99999999, 0, 4'h0, 0, 0, 1, 1,
                0, 0);
    vt[11] = mk(0, 2, 32'h104, 0, 1, 4'h0, 0, 0, 0, 2, 1,
                32'h00005500);
    vt[12] = mk(1, 1, 32'h200, 32'hFFFFABCD, 1, 4'h3, 1,
                32'hABCDABCD, 0, 1, 0, 0);
    vt[13] = mk(0, 0, 32'h203, 0, 1, 4'h0, 0, 0, 0, 2, 1,
                32'h0000ABCD);

    repeat (3) @(negedge clk);
    rstn0 = 1'b1; rstn1 = 1'b1;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("idle addr_ok0", 32'(addr_ok0), 32'd1);
      chk("idle data_ok0", 32'(data_ok0), 32'd0);
      chk("idle en0", 32'(en0), 32'd0);
      chk("idle rdata0", rdata0, 32'd0);
      chk("idle addr_ok1", 32'(addr_ok1), 32'd1);
      chk("idle data_ok1", 32'(data_ok1), 32'd0);
    end

    for (int k = 0; k < 14; k++) run_vec(k);

    // RD_LAT=3 read with req held high
    @(negedge clk);
    req1 = 1'b1; wr1 = 1'b0; size1 = 2'd2; addr1 = 32'h0;
    #1;
    chk("l3 T addr_ok", 32'(addr_ok1), 32'd1);
    chk("l3 T en", 32'(en1), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("l3 T+%0d addr_ok", c), 32'(addr_ok1), 32'd0);
      chk($sformatf("l3 T+%0d data_ok", c), 32'(data_ok1),
          32'(c == 4));
    end
    chk("l3 rdata", rdata1, 32'hCAFEF00D);
    chk("l3 err", 32'(err1), 32'd0);
    @(negedge clk);
    #1;
    chk("l3 T+5 addr_ok", 32'(addr_ok1), 32'd1);
    chk("l3 T+5 en", 32'(en1), 32'd1);
    @(negedge clk);
    req1 = 1'b0;
    #1;
    n = 1;
    while (!data_ok1 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("l3 second latency", 32'(n), 32'd4);

    // Reset pulsed at T+1 of a RD_LAT=3 read
    @(negedge clk);
    req1 = 1'b1; addr1 = 32'h0;
    #1;
    chk("rst T en", 32'(en1), 32'd1);
    @(negedge clk);
    req1 = 1'b0;
    rstn1 = 1'b0;
    #1;
    chk("rst low data_ok", 32'(data_ok1), 32'd0);
    chk("rst low rdata", rdata1, 32'd0);
    @(negedge clk);
    rstn1 = 1'b1;
    @(negedge clk);
    #1;
    chk("rst after addr_ok", 32'(addr_ok1), 32'd1);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (data_ok1) n++;
      @(negedge clk);
      #1;
    end
    chk("rst no data_ok", 32'(n), 32'd0);
    chk("rst idle addr_ok", 32'(addr_ok1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_like_bram_bridge.md
Name: sram_like_bram_bridge

Overview:
- Bridges one SRAM-like master port (datapath inst or data side) to one synchronous block RAM with per-byte write enables.
- Sits between the datapath and the RAM instance. Replaces the current direct wiring, where addr_ok/data_ok are hard-tied high and writes are word-only.
- Allows one outstanding transaction. Generates byte lanes from size/addr, handles the RAM read latency and flags misaligned accesses.

Parameters:
ADDR_W, 15, RAM word-address width; the RAM word address is addr[ADDR_W+1:2].
RD_LAT, 1, RAM read latency in cycles from en to dout valid; legal range 1..4.

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
req  in  1  master request
wr  in  1  1 = write, 0 = read
size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
addr  in  32  byte address
wdata  in  32  write data, right-justified for byte/half
addr_ok  out  1  request accepted this cycle when req & addr_ok
data_ok  out  1  one-cycle response pulse
rdata  out  32  read word, registered
err  out  1  response error flag, valid with data_ok
bram_en  out  1  RAM enable
bram_we  out  4  RAM byte write enables; bit i covers data[8i+7:8i]
bram_addr  out  ADDR_W  RAM word address
bram_din  out  32  RAM write data
bram_dout  in  32  RAM read data

Behaviour:
- Clock is clk; reset is rstn, asynchronous, active-low.
- Reset values: state = IDLE, data_ok = 0, err = 0, rdata = 0, latency counter = 0.
- Outputs follow from the reset state: addr_ok = 1, bram_en = 0, bram_we = 0.
- States: IDLE, RD_WAIT, RESP.
- addr_ok = (state == IDLE), combinational. An accept (cycle T) occurs when req & addr_ok.
- RAM drive is combinational in the accept cycle only; outside accept, bram_en = 0 and bram_we = 0:
  - bram_addr = addr[ADDR_W+1:2]
  - bram_en = 1 unless the access is misaligned
  - bram_we = wr ? lane mask : 0
- Lane mask:
  - byte: 1 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- bram_din:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Misaligned (half with addr[0] = 1, word with addr[1:0] != 0, or size = 3):
  - bram_en = 0, no RAM access.
  - Next state RESP; err = 1 at T+1 with data_ok; rdata unchanged.
- Aligned write at T: next state RESP; data_ok = 1, err = 0 at T+1.
- Aligned read at T:
  - Go to RD_WAIT with counter = RD_LAT-1.
  - In RD_WAIT, decrement the counter. When it reaches 0 (cycle T+RD_LAT), capture rdata <= bram_dout and go to RESP.
  - data_ok = 1 at T+RD_LAT+1 with the new rdata.
  - rdata returns the full RAM word; the datapath does byte/half extraction and extension.
- RESP lasts one cycle: data_ok = 1, addr_ok = 0, next state IDLE.
  - Peak throughput is one write per 2 cycles and one read per RD_LAT+2 cycles.
- rdata holds its value until the next aligned read capture. err is meaningful only while data_ok = 1 and is cleared when leaving RESP.
- req, wr, size, addr and wdata are sampled only in the accept cycle. Changes while busy are ignored. A req held through busy states is accepted in the next IDLE cycle.
- req low in IDLE: no RAM activity, state holds.
- Reset asserted mid-transaction: immediate return to the reset values. The outstanding transaction is dropped with no data_ok, and any RAM write already issued in its accept cycle stands.

Test Plan:
- Reset then idle, req = 0 -> addr_ok = 1, data_ok = 0, bram_en = 0, rdata = 0 for 10 cycles.
- Word write addr = 0x100, wdata = 0xDEADBEEF, then word read 0x100, RD_LAT = 1:
  - Write accept cycle: bram_we = 1111, bram_addr = 0x40.
  - Write response: data_ok at T+1.
  - Read response: data_ok at T+2 with rdata = 0xDEADBEEF, err = 0.
- Byte write addr = 0x103, wdata = 0x000000AA over the stored word -> bram_we = 1000, bram_din = 0xAAAAAAAA; a subsequent read returns 0xAAADBEEF.
- Half write addr = 0x102, wdata = 0x1234 -> bram_we = 1100. Half write addr = 0x101 -> err = 1 with data_ok at T+1, bram_en never high, a subsequent read returns an unchanged word.
- RD_LAT = 3, read held with req = 1 continuously -> addr_ok low for 4 cycles, data_ok at T+4. Second accept occurs at T+5.
- rstn pulsed low at T+1 of a RD_LAT = 3 read -> no data_ok ever issued, state IDLE, addr_ok = 1 one cycle after rstn rises.
